// File: rtl/dl_pipe_adder_pkg.sv
// Common types and helpers for the pipelined adder/subtractor.
package dl_pipe_adder_pkg;

   typedef enum logic {
      DL_OP_ADD = 1'b0,
      DL_OP_SUB = 1'b1
   } dl_op_e;

   // Signed overflow from the sign bits of both addends and of the result.
   function automatic logic dl_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/dl_adder_defs.vh
// Shared definitions for the design_lib adder family.
// Contains the chunk-width derivation, the parameter legality check and the
// saturation pattern helpers.
`ifndef DL_ADDER_DEFS_VH
`define DL_ADDER_DEFS_VH

// Width of one carry-chained chunk.
`define DL_CHUNK_BITS(NB, NS) ((NB) / (NS))

// Elaboration-time legality check; expands to a generate-if in module scope.
`define DL_ADDER_CHECK(NB, NS) \
   if (((NB) < 2) || ((NS) < 1) || ((NS) > (NB)) || (((NB) % (NS)) != 0)) begin : g_param_err \
      $error("dl_pipe_adder: NUM_BITS must be >= 2 and divisible by NUM_STAGES (1..NUM_BITS)"); \
   end

// Signed extremes of a W-bit two's-complement value.
`define DL_SAT_MAX(W) {1'b0, {((W) - 1){1'b1}}}
`define DL_SAT_MIN(W) {1'b1, {((W) - 1){1'b0}}}

`endif

// File: rtl/dl_pipe_adder_stage.sv
// One chunk of the pipelined adder: CHUNK_BITS adder with carry in/out plus
// its partial-sum, carry and valid registers. Everything holds when adv=0.
module dl_pipe_adder_stage
   import dl_pipe_adder_pkg::*;
#(
   parameter int CHUNK_BITS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  adv,
   input  logic                  valid_i,
   input  logic [CHUNK_BITS-1:0] a_i,
   input  logic [CHUNK_BITS-1:0] b_i,
   input  logic                  c_i,
   output logic                  valid_o,
   output logic [CHUNK_BITS-1:0] sum_o,
   output logic                  cout_o
);

   logic [CHUNK_BITS:0]   add_w;
   logic                  valid_q, valid_d;
   logic [CHUNK_BITS-1:0] sum_q, sum_d;
   logic                  cout_q, cout_d;

   assign add_w = {1'b0, a_i} + {1'b0, b_i} + (CHUNK_BITS + 1)'(c_i);

   // Load the new chunk result on advance, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      if (adv) begin
         valid_d = valid_i;
         sum_d   = add_w[CHUNK_BITS-1:0];
         cout_d  = add_w[CHUNK_BITS];
      end
   end

   // Stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign valid_o = valid_q;
   assign sum_o   = sum_q;
   assign cout_o  = cout_q;

endmodule

// File: rtl/dl_pipe_adder.sv
// Pipelined two's-complement adder/subtractor, NUM_STAGES carry-chained chunks
// with valid/ready back-pressure. The pipeline is a rigid shift: every stage
// advances together when the output is free or being consumed.
// Optional macro DL_PIPE_ADDER_SAT_EN adds a 'sat' input that clamps the
// result to the signed extreme on overflow.
`include "dl_adder_defs.vh"

module dl_pipe_adder
   import dl_pipe_adder_pkg::*;
#(
   parameter int NUM_BITS   = 32,
   parameter int NUM_STAGES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                cin,
   input  logic                sub,
`ifdef DL_PIPE_ADDER_SAT_EN
   input  logic                sat,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_BITS-1:0] sum,
   output logic                cout,
   output logic                ovf
);

   localparam int CHUNK_BITS = `DL_CHUNK_BITS(NUM_BITS, NUM_STAGES);

   `DL_ADDER_CHECK(NUM_BITS, NUM_STAGES)

   logic                adv;
   logic                c0;
   logic [NUM_BITS-1:0] b_eff;

   assign adv      = out_ready || !out_valid;
   assign in_ready = adv;
   assign b_eff    = (dl_op_e'(sub) == DL_OP_SUB) ? ~b : b;
   assign c0       = cin ^ sub;

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stg
      // Operand bits still to be summed, aligned with this stage's input.
      localparam int W = NUM_BITS - gi * CHUNK_BITS;
      logic [W-1:0]                  opa, opb;
      logic                          carry_in, valid_in;
      logic [CHUNK_BITS-1:0]         chunk_sum;
      logic                          chunk_cout, valid_out;
      // Result bits of chunks 0..gi, aligned with this stage's output.
      logic [(gi+1)*CHUNK_BITS-1:0]  res;

      if (gi == 0) begin : g_head
         assign opa      = a;
         assign opb      = b_eff;
         assign carry_in = c0;
         assign valid_in = in_valid && in_ready;
         assign res      = chunk_sum;
      end else begin : g_body
         logic [W-1:0]             opa_q, opa_d, opb_q, opb_d;
         logic [gi*CHUNK_BITS-1:0] lo_q, lo_d;

         // Stagger registers: upper operand chunks and finished lower result chunks.
         always_comb begin
            opa_d = opa_q;
            opb_d = opb_q;
            lo_d  = lo_q;
            if (adv) begin
               opa_d = g_stg[gi-1].opa[W+CHUNK_BITS-1:CHUNK_BITS];
               opb_d = g_stg[gi-1].opb[W+CHUNK_BITS-1:CHUNK_BITS];
               lo_d  = g_stg[gi-1].res;
            end
         end

         // Stagger register state.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               opa_q <= '0;
               opb_q <= '0;
               lo_q  <= '0;
            end else begin
               opa_q <= opa_d;
               opb_q <= opb_d;
               lo_q  <= lo_d;
            end
         end

         assign opa      = opa_q;
         assign opb      = opb_q;
         assign carry_in = g_stg[gi-1].chunk_cout;
         assign valid_in = g_stg[gi-1].valid_out;
         assign res      = {chunk_sum, lo_q};
      end

`ifdef DL_PIPE_ADDER_SAT_EN
      logic sat_in, sat_q, sat_d;
      if (gi == 0) begin : g_sat_head
         assign sat_in = sat;
      end else begin : g_sat_body
         assign sat_in = g_stg[gi-1].sat_q;
      end

      // Saturation request travels with its operands.
      always_comb begin
         sat_d = sat_q;
         if (adv) sat_d = sat_in;
      end

      // Saturation flag register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) sat_q <= 1'b0;
         else        sat_q <= sat_d;
      end
`endif

      dl_pipe_adder_stage #(
         .CHUNK_BITS (CHUNK_BITS)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .adv     (adv),
         .valid_i (valid_in),
         .a_i     (opa[CHUNK_BITS-1:0]),
         .b_i     (opb[CHUNK_BITS-1:0]),
         .c_i     (carry_in),
         .valid_o (valid_out),
         .sum_o   (chunk_sum),
         .cout_o  (chunk_cout)
      );

      if (gi == NUM_STAGES - 1) begin : g_tail
         logic a_msb_q, a_msb_d, b_msb_q, b_msb_d;
         logic ovf_w;

         // Capture the operand sign bits alongside the top chunk for overflow.
         always_comb begin
            a_msb_d = a_msb_q;
            b_msb_d = b_msb_q;
            if (adv) begin
               a_msb_d = opa[W-1];
               b_msb_d = opb[W-1];
            end
         end

         // Sign bit registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_msb_q <= 1'b0;
               b_msb_q <= 1'b0;
            end else begin
               a_msb_q <= a_msb_d;
               b_msb_q <= b_msb_d;
            end
         end

         assign ovf_w     = dl_ovf(a_msb_q, b_msb_q, res[NUM_BITS-1]);
         assign out_valid = valid_out;
         assign cout      = chunk_cout;
         assign ovf       = ovf_w;
`ifdef DL_PIPE_ADDER_SAT_EN
         assign sum = (sat_q && ovf_w)
                    ? (a_msb_q ? `DL_SAT_MIN(NUM_BITS) : `DL_SAT_MAX(NUM_BITS))
                    : res;
`else
         assign sum = res;
`endif
      end
   end

endmodule

// File: tb/tb_dl_pipe_adder.sv
module tb_dl_pipe_adder;
   localparam int NB = 32;
   localparam int NS = 4;
`ifdef DL_PIPE_ADDER_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NB-1:0] a = '0;
   logic [NB-1:0] b = '0;
   logic          cin = 1'b0;
   logic          sub = 1'b0;
   logic          sat_drv = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [NB-1:0] sum;
   logic          cout;
   logic          ovf;

   dl_pipe_adder #(.NUM_BITS(NB), .NUM_STAGES(NS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
`ifdef DL_PIPE_ADDER_SAT_EN
      .sat       (sat_drv),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NB-1:0] sum;
      logic          cout;
      logic          ovf;
      int            edge_no;
      bit            timed;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   txn = 0;
   bit   bp_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: arithmetic on wide integers, no chunking.
   function automatic exp_t model(input logic [NB-1:0] ta, input logic [NB-1:0] tb,
                                  input logic tc, input logic ts, input logic tsat, input bit timed);
      exp_t   e;
      longint ua, ub, sa, sb, ur, sr, smax, smin, ci;
      ua = longint'(ta);
      ub = longint'(tb);
      sa = longint'($signed(ta));
      sb = longint'($signed(tb));
      ci = longint'(tc);
      ur = ts ? (ua - ub - ci) : (ua + ub + ci);
      sr = ts ? (sa - sb - ci) : (sa + sb + ci);
      smax = (64'sd1 <<< (NB - 1)) - 1;
      smin = -(64'sd1 <<< (NB - 1));
      e.sum  = ur[NB-1:0];
      e.cout = ts ? (ur >= 0) : (ur >= (64'sd1 <<< NB));
      e.ovf  = (sr > smax) || (sr < smin);
      if (SAT_ON && tsat && e.ovf)
         e.sum = ta[NB-1] ? {1'b1, {(NB-1){1'b0}}} : {1'b0, {(NB-1){1'b1}}};
      e.edge_no = 0;
      e.timed   = timed;
      return e;
   endfunction

   function automatic exp_t mk(input logic [NB-1:0] s, input logic c, input logic o);
      exp_t e;
      e.sum = s; e.cout = c; e.ovf = o; e.edge_no = 0; e.timed = 1'b1;
      return e;
   endfunction

   // Monitor: pops the scoreboard on every output transfer.
   logic [NB-1:0] hold_sum;
   logic          hold_cout, hold_ovf;
   bit            stalled = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      int   lat;
      if (rst_n) begin
         checks++;
         if (in_ready !== (out_ready || !out_valid)) begin
            errors++;
            $display("FAIL in_ready_adv: in_ready=%b out_ready=%b out_valid=%b", in_ready, out_ready, out_valid);
         end
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || sum !== hold_sum || cout !== hold_cout || ovf !== hold_ovf) begin
               errors++;
               $display("FAIL stall_hold: got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                        out_valid, sum, cout, ovf, hold_sum, hold_cout, hold_ovf);
            end
         end
         stalled   = (out_valid === 1'b1) && (out_ready === 1'b0);
         hold_sum  = sum;
         hold_cout = cout;
         hold_ovf  = ovf;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: sum=%h with empty scoreboard", sum);
            end else begin
               e = q.pop_front();
               txn++;
               $display("txn %0d sum=%h cout=%b ovf=%b (want %h %b %b)", txn, sum, cout, ovf, e.sum, e.cout, e.ovf);
               if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                  errors++;
                  $display("FAIL result: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                           sum, cout, ovf, e.sum, e.cout, e.ovf);
               end
               if (e.timed) begin
                  lat = cyc + 1 - e.edge_no;
                  checks++;
                  if (lat != NS) begin
                     errors++;
                     $display("FAIL latency: got %0d want %0d", lat, NS);
                  end
               end
            end
         end
      end else begin
         stalled = 1'b0;
      end
   end

   // Random output back-pressure while enabled.
   initial forever begin
      @(posedge clk);
      #1;
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send(input logic [NB-1:0] ta, input logic [NB-1:0] tb, input logic tc,
                       input logic ts, input logic tsat, input exp_t e);
      bit done = 1'b0;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         a = ta; b = tb; cin = tc; sub = ts; sat_drv = tsat;
         #1;
         if (in_ready) begin
            e.edge_no = cyc + 1;
            q.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready stuck low");
      end
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
   endtask

   task automatic send_rand(input bit timed);
      logic [NB-1:0] ta, tb;
      logic tc, ts, tsat;
      ta = $urandom; tb = $urandom;
      if ($urandom_range(0, 7) == 0) ta = {1'b0, {(NB-1){1'b1}}};
      if ($urandom_range(0, 7) == 0) tb = '1;
      tc = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      tsat = 1'($urandom_range(0, 1));
      send(ta, tb, tc, ts, tsat, model(ta, tb, tc, ts, tsat, timed));
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results never appeared", q.size());
      end
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks += 5;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (in_ready  !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      if (sum !== '0)         begin errors++; $display("FAIL rst_sum: got %h want 0", sum); end
      if (cout !== 1'b0)      begin errors++; $display("FAIL rst_cout: got %b want 0", cout); end
      if (ovf !== 1'b0)       begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end

      // Directed boundaries, full rate.
      @(posedge clk); #1 out_ready = 1'b1;
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
      send(32'h5, 32'h7, 1'b0, 1'b1, 1'b0, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
      send(32'h7, 32'h5, 1'b1, 1'b1, 1'b0, mk(32'h0000_0001, 1'b1, 1'b0));
      send(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, mk(32'h0000_0001, 1'b0, 1'b0));

      // Streaming, back-to-back.
      for (int i = 0; i < 100; i++) send_rand(1'b1);
      idle();
      drain();

      // Random back-pressure and random input gaps.
      bp_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 2) == 0) idle();
         send_rand(1'b0);
      end
      idle();
      @(posedge clk); #1 bp_en = 1'b0; out_ready = 1'b1;
      drain();

`ifdef DL_PIPE_ADDER_SAT_EN
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
      send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, mk(32'h8000_0000, 1'b1, 1'b1));
      send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
      send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
      idle();
      drain();
`endif

      // Reset with three operations in flight: nothing may come out.
      for (int i = 0; i < 3; i++) send_rand(1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      in_valid = 1'b0;
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks += 2;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush_valid: cycle %0d got %b want 0", i, out_valid); end
         if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_flush_ready: cycle %0d got %b want 1", i, in_ready); end
      end

      // Pipeline still works after the mid-stream reset.
      send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
      idle();
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
